// File: rtl/acc_datapath.sv
// Purpose : accumulator-machine datapath (PC, IR, MDR, A, 2**AW x DW memory) steered by control-unit lines.
// Latency : registers update on the clock edge after the control lines are set; Aeq0/Apos/IR follow registers combinationally.
// Backpress: none; Halted (sticky) or prog_en freeze all architectural state and ignore control lines.
//
// Ports:
//   clock, reset (async, active-low)
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt : control-unit lines
//   Input[DW-1:0]                                          : value loaded into A when Asel=01
//   prog_en, prog_we, prog_addr[AW-1:0], prog_data[DW-1:0] : memory programming port
//   IR[2:0], Aeq0, Apos                                    : status back to the control unit
//   A_out, PC_out, Halted                                  : observation outputs
//   OVF                                                    : sticky signed overflow, only when ACC_OVF_EN is defined
module acc_datapath #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic          Halt,
  input  logic [DW-1:0] Input,
  input  logic          prog_en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] A_out,
  output logic [AW-1:0] PC_out,
`ifdef ACC_OVF_EN
  output logic          OVF,
`endif
  output logic          Halted
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] mdr_q;
  logic [DW-1:0] a_q;
  logic          halted_q;

  logic          run;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] mem_pc;
  logic [DW-1:0] addend;
  logic [DW-1:0] sum;
  logic [DW-1:0] a_next;
  logic [AW-1:0] pc_next;

  // Programming mode and the halted state both freeze the machine.
  assign run      = ~halted_q & ~prog_en;
  assign ir_addr  = ir_q[AW-1:0];
  assign mem_addr = Meminst ? ir_addr : pc_q;
  assign mem_rd   = mem[mem_addr];
  assign mem_pc   = mem[pc_q];

  // Subtraction as A + ~MDR + 1 so one adder serves both operations.
  assign addend   = Sub ? ~mdr_q : mdr_q;
  assign sum      = a_q + addend + DW'(Sub);
  assign pc_next  = JMPmux ? ir_addr : pc_q + AW'(1);

  always_comb begin
    a_next = '0;
    unique case (Asel)
      2'b00:   a_next = sum;
      2'b01:   a_next = Input;
      2'b10:   a_next = mdr_q;
      default: a_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      halted_q <= 1'b0;
    end else if (run) begin
      mdr_q <= mem_rd;
      if (IRload) ir_q <= mem_pc;
      if (PCload) pc_q <= pc_next;
      // An A write on the same edge as Halt still lands; the freeze starts afterwards.
      if (Aload)  a_q  <= a_next;
      if (Halt)   halted_q <= 1'b1;
    end
  end

  // Memory is not reset so a program survives a reset. The programming port
  // has priority; CPU stores always target the IR address field.
  always_ff @(posedge clock) begin
    if (prog_en) begin
      if (prog_we) mem[prog_addr] <= prog_data;
    end else if (!halted_q && MemWr) begin
      mem[ir_addr] <= a_q;
    end
  end

`ifdef ACC_OVF_EN
  logic ovf_q;
  logic ovf_set;

  // Add overflows when operands share a sign the result lacks; subtract
  // overflows when operand signs differ and the result sign departs from A.
  assign ovf_set = (Sub ? (a_q[DW-1] != mdr_q[DW-1]) : (a_q[DW-1] == mdr_q[DW-1]))
                   && (sum[DW-1] != a_q[DW-1]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (run && Aload) begin
      if (Asel != 2'b00)  ovf_q <= 1'b0;
      else if (ovf_set)   ovf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
`endif

  assign IR     = ir_q[DW-1:DW-3];
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[DW-1];
  assign A_out  = a_q;
  assign PC_out = pc_q;
  assign Halted = halted_q;

endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
- Accumulator-machine datapath driven by the processor control unit's FSM control lines (IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt).
- Returns status to the control unit: IR opcode, Aeq0, Apos.
- Holds PC, IR, memory data register (MDR), accumulator A, and a 32x8 unified program/data memory.
- Includes a programming port for loading memory before a run.

Parameters:
- DW, 8, accumulator / memory word width (instruction = opcode[2:0] + address[4:0] when DW=8)
- AW, 5, memory address width; depth = 2**AW

Ports:
- clock  in  1  system clock (same 1 s tick that drives the control unit)
- reset  in  1  asynchronous, active-low reset
- IRload  in  1  load IR from memory at PC
- JMPmux  in  1  PC source: 0 = PC+1, 1 = IR address field
- PCload  in  1  PC write enable
- Meminst  in  1  memory address source: 0 = PC, 1 = IR[AW-1:0]
- MemWr  in  1  write A to memory
- Asel  in  2  A source: 00 adder/subtractor, 01 Input, 10 MDR, 11 zero
- Aload  in  1  A write enable
- Sub  in  1  0 = A+MDR, 1 = A-MDR
- Halt  in  1  freeze request
- Input  in  DW  external data value for the IN instruction
- prog_en  in  1  programming mode
- prog_we  in  1  programming write strobe
- prog_addr  in  AW  programming address
- prog_data  in  DW  programming data
- IR  out  3  opcode field, IR[DW-1:DW-3]
- Aeq0  out  1  A == 0
- Apos  out  1  ~A[DW-1], i.e. A non-negative
- A_out  out  DW  accumulator value
- PC_out  out  AW  program counter value
- Halted  out  1  sticky halt indicator

Behaviour:
- Reset (reset=0, async): PC=0, IR=0, MDR=0, A=0, Halted=0, and the optional OVF flag = 0. Memory is not reset; its contents survive a reset.
- Memory reads:
  - Combinational read at mem_addr = Meminst ? IR[AW-1:0] : PC.
  - MDR <= mem[mem_addr] every clock unless frozen.
  - The operand latched during decode (Meminst=1) is therefore valid in the following load/add/sub cycle.
- Memory writes: synchronous, MemWr=1 gives mem[IR[AW-1:0]] <= A. The address is always the IR field, regardless of Meminst.
- IRload=1: IR <= mem[PC] (combinational read, same edge).
- PCload=1: PC <= JMPmux ? IR[AW-1:0] : PC+1. PC+1 wraps 31 -> 0.
- Aload=1: A <= mux(Asel).
  - Adder result = A ± MDR, DW-bit two's complement with wrap and no saturation.
  - Sub=1 is computed as A + ~MDR + 1.
- Aeq0 and Apos are combinational from A. They update the cycle after an A write.
- Fetch cycle (IRload=1, PCload=1, JMPmux=0): IR gets the old mem[PC]; PC increments. Both happen on the same edge.
- Halt:
  - Halt=1 at an edge sets Halted=1.
  - While Halted=1, PC, IR, A, MDR and memory writes are frozen and all control inputs are ignored.
  - Halted clears only on reset.
- Programming mode (prog_en=1):
  - All control inputs are ignored; PC, IR, A, MDR hold.
  - prog_we=1 gives mem[prog_addr] <= prog_data.
  - Allowed both while Halted and while running.
- Simultaneous events:
  - prog_we with MemWr: prog wins, MemWr is dropped.
  - Aload with Halt on the same edge: the A write completes, then freeze.
  - Reset asserted mid-instruction aborts immediately; memory keeps its last completed write.
- Undefined control combinations (e.g. IRload and Aload together) each act independently; no arbitration.

Optional Feature:
- Macro ACC_OVF_EN.
- Defined:
  - Adds output OVF (1 bit), a sticky signed-overflow flag.
  - Set when Aload=1, Asel=00 and the result sign is inconsistent: add with operands of the same sign and a result of opposite sign; sub with operands of different sign and a result sign differing from A.
  - Cleared on reset or on any Aload with Asel=01/10/11.
  - Frozen while Halted.
- Undefined: no OVF port; arithmetic is unchanged (wraps silently).

Test Plan:
- Program via prog port: mem[0]=0x85 (IN), mem[1]=0x4A (ADD 10), mem[2]=0x2B (STORE 11), mem[3]=0xE0 (HALT), mem[10]=0x07. Drive control-unit sequences with Input=0x05 -> after ADD, A=0x0C; after STORE, mem[11]=0x0C; after HALT, Halted=1 and PC=4 holds.
- Fetch at PC=31 -> PC wraps to 0; IR = old mem[31][7:5].
- A=0x03, MDR=0x05, Sub=1, Aload -> A=0xFE, Apos=0, Aeq0=0. With ACC_OVF_EN defined, OVF=0. A=0x7F plus 0x01 -> A=0x80, OVF=1.
- A=0 then JZ control (JMPmux=1, PCload=Aeq0=1, IR addr=0x14) -> PC=0x14. Repeat with A=0x01 -> PCload=0, so PC holds.
- Assert reset mid-add with A=0x33 -> A=0, PC=0, IR=0 immediately (no clock needed); mem[10] still 0x07.
- Same edge prog_we (addr 11, data 0xAA) with MemWr (A=0x55, IR addr 11) -> mem[11]=0xAA.
